// File: rtl/mdu_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: FSM states, funct3 codes
// and operand-signedness helpers.
package mdu_sequencer_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_op_e;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_sequencer_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring divide.
// Accumulator layout is {hi[XLEN:0], lo[XLEN-1:0]}; for divide hi is the partial remainder.
module mdu_step
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic              div_i,
    input  logic [2*XLEN:0]   acc_i,
    input  logic [XLEN-1:0]   opb_i,
    output logic [2*XLEN:0]   acc_o,
    output logic              qbit_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] prem;
    logic [XLEN:0] rem_next;

    always_comb begin
        mul_sum  = acc_i[2*XLEN:XLEN] + {1'b0, (acc_i[0] ? opb_i : {XLEN{1'b0}})};
        // Shift the next dividend bit into the partial remainder before the trial subtract.
        prem     = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        qbit_o   = (prem >= {1'b0, opb_i});
        rem_next = qbit_o ? (prem - {1'b0, opb_i}) : prem;
        if (div_i) begin
            acc_o = {rem_next, acc_i[XLEN-2:0], qbit_o};
        end else begin
            acc_o = {1'b0, mul_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle sequencer: stalls EX while iterating XLEN steps on operand
// magnitudes, fixes the sign, then presents the result with a one-cycle done pulse.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       f3_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2*XLEN:0]   step_acc;
    logic              step_qbit;
    logic              a_neg, b_neg, res_neg, special;
    logic [XLEN-1:0]   a_abs, b_abs, special_res, quot_s, rem_s, fix_res;
    logic [2*XLEN-1:0] prod_s;
    logic              stall;

    mdu_step #(.XLEN(XLEN)) u_step (
        .div_i  (f3_q[2]),
        .acc_i  (acc_q),
        .opb_i  (opb_q),
        .acc_o  (step_acc),
        .qbit_o (step_qbit)
    );

    always_comb begin
        a_neg   = op_a_signed(f3_i) & a_i[XLEN-1];
        b_neg   = op_b_signed(f3_i) & b_i[XLEN-1];
        a_abs   = a_neg ? (~a_i + 1'b1) : a_i;
        b_abs   = b_neg ? (~b_i + 1'b1) : b_i;
        // Remainder takes the dividend's sign; product and quotient take a^b.
        res_neg = (f3_i[2] && f3_i[1]) ? a_neg : (a_neg ^ b_neg);
        special = f3_i[2] && ((b_i == '0) || (!f3_i[0] && (a_i == INT_MIN) && (b_i == '1)));
        if (b_i == '0) begin
            special_res = f3_i[1] ? a_i : '1;
        end else begin
            special_res = f3_i[1] ? '0 : INT_MIN;
        end

        prod_s = neg_q ? (~acc_q[2*XLEN-1:0] + 1'b1) : acc_q[2*XLEN-1:0];
        quot_s = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_s  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                      fix_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fix_res = quot_s;
            default:                     fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        stall    = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start_i && !flush_i) begin
                    stall   = 1'b1;
                    f3_d    = f3_i;
                    neg_d   = res_neg;
                    cnt_d   = '0;
                    acc_d   = {{(XLEN+1){1'b0}}, a_abs};
                    opb_d   = b_abs;
                    if (special) begin
                        result_d = special_res;
                        state_d  = MDU_DONE;
                    end else begin
                        state_d  = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
                stall = 1'b1;
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                stall    = 1'b1;
                result_d = fix_res;
                state_d  = MDU_DONE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d  = MDU_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MDU_IDLE;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // Stall must drop while reset is held, even if EX keeps start asserted.
    assign stall_o  = rst_ni & stall;
    assign done_o   = (state_q == MDU_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against an arithmetic reference model.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        stall, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .flush_i  (flush),
        .f3_i     (f3),
        .a_i      (a),
        .b_i      (b),
        .stall_o  (stall),
        .done_o   (done),
        .result_o (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_special(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        if (!f[2]) return 1'b0;
        if (bv == 32'd0) return 1'b1;
        return (f == 3'b100 || f == 3'b110) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, ua, ub, p;
        int ia, ib, q;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = longint'({32'd0, av});
        ub = longint'({32'd0, bv});
        ia = $signed(av);
        ib = $signed(bv);
        case (f)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (bv == 0) return 32'hFFFF_FFFF;
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib; return q;
            end
            3'b101: return (bv == 0) ? 32'hFFFF_FFFF : av / bv;
            3'b110: begin
                if (bv == 0) return av;
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'd0;
                q = ia % ib; return q;
            end
            default: return (bv == 0) ? av : av % bv;
        endcase
    endfunction

    // Cycle 0 is the cycle in which start is first seen in IDLE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv, input bit already);
        int lat, done_cyc;
        logic [63:0] sv, exp_sv;
        logic [31:0] res, exp;
        lat = ref_special(f, av, bv) ? 1 : 34;
        exp = ref_mdu(f, av, bv);
        if (!already) begin
            @(posedge clk); #1;
            start = 1'b1; f3 = f; a = av; b = bv;
        end
        done_cyc = -1;
        sv = '0;
        res = '0;
        for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            sv[cyc] = stall;
            if (done) begin
                done_cyc = cyc;
                res = result;
            end
        end
        exp_sv = (64'd1 << lat) - 64'd1;
        chk($sformatf("latency f3=%0d", f), 64'(done_cyc), 64'(lat));
        chk($sformatf("stall f3=%0d", f), sv, exp_sv);
        chk($sformatf("result f3=%0d a=%h b=%h", f, av, bv), 64'(res), 64'(exp));
        last_exp = exp;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; flush = 1'b0; f3 = 3'b000; a = 32'd7; b = 32'd3;
        #12;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 1'b0);
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 1'b0);
        run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 1'b0);
        run_op(3'b100, 32'd5, 32'd0, 1'b0);
        run_op(3'b110, 32'd5, 32'd0, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Flush at cycle 10 of a MUL, then a DIVU from cycle 12.
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'b000; a = 32'd1234; b = 32'd5678;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", 64'(stall), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        chk("flush_result", 64'(result), 64'(last_exp));
        run_op(3'b101, 32'd1000, 32'd33, 1'b0);

        // Reset at cycle 20 of a DIV with start held through release.
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'b100; a = 32'hFFFF_F000; b = 32'd9;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(3'b100, 32'hFFFF_F000, 32'd9, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
